// File: rtl/run_length_detector.sv
// run_length_detector: counts consecutive equal sampled bits on a serial input,
// flags runs of at least RUN_LEN ones and/or zeros, and reports the length of
// each detected run when it ends.
`timescale 1ns/1ps

module run_length_detector #(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic [1:0]       mode,
  output logic             y,
  output logic             y_one,
  output logic             y_zero,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_cnt,
  output logic             run_end,
  output logic [CNT_W-1:0] end_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RUN_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DETECT = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       mode_q;
  logic             run_bit_d;
  logic [CNT_W-1:0] run_cnt_d;
  logic [CNT_W-1:0] end_len_d;
  logic             run_end_d;
  logic             y_one_d;
  logic             y_zero_d;
  logic             old_pol_en;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment of the current run length.
  always_comb begin
    cnt_inc = run_cnt;
    if (run_cnt != CNT_MAX) begin
      cnt_inc = run_cnt + CNT_ONE;
    end
  end

  // Detection enable for the polarity of the run currently in progress.
  always_comb begin
    old_pol_en = run_bit ? mode_q[0] : mode_q[1];
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      run_bit <= 1'b0;
      run_cnt <= '0;
      end_len <= '0;
      run_end <= 1'b0;
      y_one   <= 1'b0;
      y_zero  <= 1'b0;
      y       <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      run_bit <= run_bit_d;
      run_cnt <= run_cnt_d;
      end_len <= end_len_d;
      run_end <= run_end_d;
      y_one   <= y_one_d;
      y_zero  <= y_zero_d;
      y       <= y_one_d | y_zero_d;
    end
  end

  // Next-state, next-count and run-end decision for each qualified sample.
  always_comb begin
    state_d   = state_q;
    run_bit_d = run_bit;
    run_cnt_d = run_cnt;
    end_len_d = end_len;
    run_end_d = 1'b0;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          run_bit_d = x;
          run_cnt_d = CNT_ONE;
          state_d   = COUNT;
        end
        COUNT, DETECT: begin
          if (x == run_bit) begin
            run_cnt_d = cnt_inc;
            state_d   = (cnt_inc >= THRESH) ? DETECT : COUNT;
          end else begin
            run_bit_d = x;
            run_cnt_d = CNT_ONE;
            state_d   = COUNT;
            // Only a detected run of an enabled polarity reports its length.
            if ((state_q == DETECT) && old_pol_en) begin
              run_end_d = 1'b1;
              end_len_d = run_cnt;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Flags follow the next state and the mode being registered this edge,
  // so a mode change shows up one edge later without needing a sample.
  always_comb begin
    y_one_d  = (state_d == DETECT) &  run_bit_d & mode[0];
    y_zero_d = (state_d == DETECT) & ~run_bit_d & mode[1];
  end

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector: a vector table for the main
// sequence, plus hand-written reset and saturation sequences.
`timescale 1ns/1ps

module tb_run_length_detector;

  logic       clk;
  logic       reset;
  logic       en;
  logic       x;
  logic [1:0] mode;
  logic       y, y_one, y_zero, run_bit, run_end;
  logic [7:0] run_cnt, end_len;

  logic       en2;
  logic       x2;
  logic       y2, y_one2, y_zero2, run_bit2, run_end2;
  logic [2:0] run_cnt2, end_len2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       en;
    logic       x;
    logic [1:0] mode;
    logic       y;
    logic       y_one;
    logic       y_zero;
    logic       run_bit;
    logic [7:0] run_cnt;
    logic       run_end;
    logic [7:0] end_len;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  run_length_detector #(.RUN_LEN(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .mode(mode),
    .y(y), .y_one(y_one), .y_zero(y_zero), .run_bit(run_bit),
    .run_cnt(run_cnt), .run_end(run_end), .end_len(end_len)
  );

  run_length_detector #(.RUN_LEN(3), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .en(en2), .x(x2), .mode(mode),
    .y(y2), .y_one(y_one2), .y_zero(y_zero2), .run_bit(run_bit2),
    .run_cnt(run_cnt2), .run_end(run_end2), .end_len(end_len2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic chk_all_zero(input string name, input int idx);
    chk({name, ".y"}, idx, 32'(y), 32'd0);
    chk({name, ".y_one"}, idx, 32'(y_one), 32'd0);
    chk({name, ".y_zero"}, idx, 32'(y_zero), 32'd0);
    chk({name, ".run_bit"}, idx, 32'(run_bit), 32'd0);
    chk({name, ".run_cnt"}, idx, 32'(run_cnt), 32'd0);
    chk({name, ".run_end"}, idx, 32'(run_end), 32'd0);
    chk({name, ".end_len"}, idx, 32'(end_len), 32'd0);
  endtask

  initial begin
    //          en    x     mode   y     y1    y0    rb    cnt   re    el
    vecs[0]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'd3};
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 8'd3};
    vecs[5]  = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 8'd3};
    vecs[6]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'd3};
    // en gap: x ignored, count held, no run_end
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd3};
    vecs[8]  = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd3};
    vecs[9]  = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd3};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd3};
    vecs[11] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd3};
    vecs[12] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 8'd3};
    vecs[13] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 8'd3};
    // mode 01: the ones run ends under old mode 11, zeros run is not flagged
    vecs[14] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'd3};
    vecs[15] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 8'd3};
    vecs[16] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd3};
    vecs[17] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 8'd3};
    // mode 10 with en=0: y_zero appears one edge later
    vecs[18] = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 8'd3};
    vecs[19] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'd4};
    // mode 00: detection but no flag, no run_end
    vecs[20] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 8'd4};
    vecs[21] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 8'd4};
    vecs[22] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'd4};
    // run_end lasts one cycle even when en drops right after
    vecs[23] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 8'd4};
    vecs[24] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 8'd4};
    vecs[25] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'd3};
    vecs[26] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd3};
    // build a detected ones run for the reset test
    vecs[27] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 8'd3};
    vecs[28] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 8'd3};

    reset = 1'b1; en = 1'b0; x = 1'b0; mode = 2'b00; en2 = 1'b0; x2 = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset", 0);
    reset = 1'b0;

    // Table-driven main sequence
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      en = vecs[i].en; x = vecs[i].x; mode = vecs[i].mode;
      @(posedge clk);
      #1;
      chk("y", i, 32'(y), 32'(vecs[i].y));
      chk("y_one", i, 32'(y_one), 32'(vecs[i].y_one));
      chk("y_zero", i, 32'(y_zero), 32'(vecs[i].y_zero));
      chk("run_bit", i, 32'(run_bit), 32'(vecs[i].run_bit));
      chk("run_cnt", i, 32'(run_cnt), 32'(vecs[i].run_cnt));
      chk("run_end", i, 32'(run_end), 32'(vecs[i].run_end));
      chk("end_len", i, 32'(end_len), 32'(vecs[i].end_len));
    end

    // Asynchronous reset while in DETECT
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst", 0);
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold", 0);
    @(negedge clk);
    reset = 1'b0; en = 1'b1; x = 1'b1; mode = 2'b11;
    @(posedge clk);
    #1;
    chk("post_rst.run_cnt", 0, 32'(run_cnt), 32'd1);
    chk("post_rst.y", 0, 32'(y), 32'd0);
    chk("post_rst.run_bit", 0, 32'(run_bit), 32'd1);
    chk("post_rst.run_end", 0, 32'(run_end), 32'd0);
    @(negedge clk);
    en = 1'b0;

    // Saturation on the 3-bit counter instance
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      en2 = 1'b1; x2 = 1'b1;
      @(posedge clk);
      #1;
      chk("sat.run_cnt", i, 32'(run_cnt2), (i > 7) ? 32'd7 : 32'(i));
      chk("sat.y", i, 32'(y2), (i >= 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    x2 = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_end.run_end", 0, 32'(run_end2), 32'd1);
    chk("sat_end.end_len", 0, 32'(end_len2), 32'd7);
    chk("sat_end.run_cnt", 0, 32'(run_cnt2), 32'd1);
    chk("sat_end.y", 0, 32'(y2), 32'd0);
    @(negedge clk);
    en2 = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_end.pulse", 1, 32'(run_end2), 32'd0);
    chk("sat_end.held", 1, 32'(end_len2), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
